// File: rtl/qsysp01_sw_poll_master_if.sv
// Avalon-MM read-only bus between the switch poll master and the switch PIO slave (s1).
interface qsysp01_sw_poll_master_if;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata
  );
endinterface

// File: rtl/qsysp01_sw_poll_master.sv
// Avalon-MM switch poll master: periodic reads of PIO data register, debounced word with change strobe.
// Optional POLL_TIMEOUT_EN: abandon a read stalled for 256 cycles and raise sticky bus_timeout.
module qsysp01_sw_poll_master #(
  parameter int DATA_W       = 18,
  parameter int POLL_DIV     = 50000,
  parameter int DEBOUNCE     = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         poll_en,
  qsysp01_sw_poll_master_if.master     bus,
  output logic [DATA_W-1:0]            sw_value,
  output logic                         sw_valid,
  output logic                         sw_changed,
  output logic                         bus_timeout
);

  localparam int TIMER_W = $clog2(POLL_DIV);
  localparam int LAT_W   = $clog2(READ_LATENCY + 1);
  localparam int MATCH_W = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, EVAL} state_t;

  state_t              state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic                capture;
  logic                eval;
  logic                stall_expired;

  logic [DATA_W-1:0]   sample_q;
  logic [DATA_W-1:0]   cand_q, cand_d;
  logic [MATCH_W-1:0]  match_q, match_d;
  logic                accept;
  logic                unused_rd;

  assign bus.avm_address = '0;
  assign bus.avm_read    = (state_q == REQ);
  assign unused_rd       = ^bus.avm_readdata;

`ifdef POLL_TIMEOUT_EN
  logic [7:0] stall_q;

  assign stall_expired = bus.avm_waitrequest && (stall_q == 8'hFF);

  always_ff @(posedge clk) begin
    if (reset || state_q != REQ) begin
      stall_q <= '0;
    end else if (bus.avm_waitrequest) begin
      stall_q <= stall_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus_timeout <= 1'b0;
    end else if (state_q == REQ && stall_expired) begin
      bus_timeout <= 1'b1;
    end
  end
`else
  assign stall_expired = 1'b0;
  assign bus_timeout   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      lat_q   <= lat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    lat_d   = lat_q;
    capture = 1'b0;
    eval    = 1'b0;
    case (state_q)
      IDLE: begin
        if (poll_en) begin
          if (timer_q == TIMER_W'(POLL_DIV - 1)) begin
            timer_d = '0;
            state_d = REQ;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      REQ: begin
        if (!bus.avm_waitrequest) begin
          lat_d   = '0;
          state_d = WAIT;
        end else if (stall_expired) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (lat_q == LAT_W'(READ_LATENCY - 1)) begin
          capture = 1'b1;
          state_d = EVAL;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      EVAL: begin
        eval    = 1'b1;
        timer_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sample_q <= '0;
    end else if (capture) begin
      sample_q <= bus.avm_readdata[DATA_W-1:0];
    end
  end

  // Candidate/run-length update; acceptance is judged on the updated run so DEBOUNCE=1 accepts at once.
  always_comb begin
    cand_d  = cand_q;
    match_d = match_q;
    if (sample_q != cand_q) begin
      cand_d  = sample_q;
      match_d = MATCH_W'(1);
    end else if (match_q != MATCH_W'(DEBOUNCE)) begin
      match_d = match_q + 1'b1;
    end
    accept = (match_d == MATCH_W'(DEBOUNCE)) && ((cand_d != sw_value) || !sw_valid);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cand_q     <= '0;
      match_q    <= '0;
      sw_value   <= '0;
      sw_valid   <= 1'b0;
      sw_changed <= 1'b0;
    end else begin
      sw_changed <= 1'b0;
      if (eval) begin
        cand_q  <= cand_d;
        match_q <= match_d;
        if (accept) begin
          sw_value   <= cand_d;
          sw_valid   <= 1'b1;
          sw_changed <= 1'b1;
        end
      end
    end
  end

endmodule
